// File: rtl/p_to_s_pkg.sv
// ============================================================================
// p_to_s_pkg : shared constants, state type and helpers for p_to_s
// Rev 1.0
// ============================================================================
`default_nettype none

package p_to_s_pkg;

  localparam int P2S_W = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/p_to_s_hold_buf.sv
// ============================================================================
// p_to_s_hold_buf : one-entry word buffer (push/pop/full)
// Rev 1.0
// ============================================================================
`default_nettype none

module p_to_s_hold_buf #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] data_q;
  logic         full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (push_i) begin
        data_q <= data_i;
        full_q <= 1'b1;
      end else if (pop_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

`default_nettype wire

// File: rtl/p_to_s.sv
// ============================================================================
// p_to_s : parallel-to-serial transmitter with one-word holding buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module p_to_s
  import p_to_s_pkg::*;
#(
  parameter int W         = P2S_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_a,
  input  logic [W-1:0] data_a,
  output logic         ready_a,
  output logic         valid_b,
  output logic         data_b,
  output logic         last_b,
  input  logic         ready_b
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  shifted;
  logic          head_bit;
  logic          buf_full;
  logic [W-1:0]  buf_data;
  logic          bit_xfer, finish, accept, load_direct, push, pop;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_bit = shift_q[W-1];
      assign shifted  = {shift_q[W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit = shift_q[0];
      assign shifted  = {1'b0, shift_q[W-1:1]};
    end
  endgenerate

  p_to_s_hold_buf #(.W(W)) u_hold_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .data_i (data_a),
    .data_o (buf_data),
    .full_o (buf_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    valid_b     = (state_q == SHIFT);
    data_b      = valid_b & head_bit;
    last_b      = valid_b && (cnt_q == CNT_LAST);
    ready_a     = !buf_full;
    bit_xfer    = valid_b && ready_b;
    finish      = bit_xfer && last_b;
    accept      = valid_a && ready_a;
    // a direct load needs the shifter free now or emptying on this edge
    load_direct = accept && ((state_q == IDLE) || finish);
    push        = accept && !load_direct;
    pop         = finish && buf_full;

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    if (pop) begin
      shift_d = buf_data;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (load_direct) begin
      shift_d = data_a;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (finish) begin
      shift_d = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (bit_xfer) begin
      shift_d = shifted;
      cnt_d   = cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire
